// File: rtl/ex_muldiv_unit.sv
// EX-stage forwarding operand mux plus a 32-iteration unsigned MUL/DIV/REM engine
// that stalls the pipeline from the start cycle until the result is ready.
module ex_muldiv_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [1:0]  op_i,
  input  logic        flush_i,
  input  logic [31:0] Rs_data_i,
  input  logic [31:0] Rt_data_i,
  input  logic [31:0] EX_MEM_data_i,
  input  logic [31:0] MEM_WB_data_i,
  input  logic [1:0]  Rs_fwd_i,
  input  logic [1:0]  Rt_fwd_i,
  output logic [31:0] rs_op_o,
  output logic [31:0] rt_op_o,
  output logic [31:0] result_o,
  output logic        done_o,
  output logic        stall_o
);

  // state  | meaning
  // S_IDLE | waiting for a MUL/DIV/REM start cycle
  // S_BUSY | one shift-add or restoring-divide iteration per cycle
  // S_DONE | result_o valid, done_o pulses, back to S_IDLE next cycle
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic        dz_q, dz_d;
  logic [63:0] rq_q, rq_d;
  logic [31:0] result_q, result_d;
  logic [32:0] diff;
  logic        start_w;

  always_comb begin
    unique case (Rs_fwd_i)
      2'b10:   rs_op_o = EX_MEM_data_i;
      2'b01:   rs_op_o = MEM_WB_data_i;
      default: rs_op_o = Rs_data_i;
    endcase
    unique case (Rt_fwd_i)
      2'b10:   rt_op_o = EX_MEM_data_i;
      2'b01:   rt_op_o = MEM_WB_data_i;
      default: rt_op_o = Rt_data_i;
    endcase
  end

  assign start_w  = (state_q == S_IDLE) && valid_i && (op_i != 2'b00) && !flush_i;
  assign stall_o  = start_w || ((state_q == S_BUSY) && !flush_i);
  assign done_o   = (state_q == S_DONE) && !flush_i;
  assign result_o = result_q;

  // Trial subtract of the divisor from the shifted-in upper half; bit 32 is the borrow.
  assign diff = {1'b0, rq_q[62:31]} - {1'b0, b_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    dz_d     = dz_q;
    rq_d     = rq_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_w) begin
          state_d = S_BUSY;
          a_d     = rs_op_o;
          b_d     = rt_op_o;
          op_d    = op_i;
          cnt_d   = 5'd0;
          dz_d    = (rt_op_o == 32'd0);
          rq_d    = (op_i == OP_MUL) ? 64'd0 : {32'd0, rs_op_o};
        end
      end
      S_BUSY: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (op_q == OP_MUL) begin
            if (b_q[0]) rq_d[31:0] = rq_q[31:0] + a_q;
            a_d = {a_q[30:0], 1'b0};
            b_d = {1'b0, b_q[31:1]};
          end else if (diff[32]) begin
            rq_d = {rq_q[62:0], 1'b0};
          end else begin
            rq_d = {diff[31:0], rq_q[30:0], 1'b1};
          end
          if (cnt_q == 5'd31) begin
            state_d = S_DONE;
            if (op_q == OP_MUL)      result_d = rq_d[31:0];
            else if (op_q == OP_DIV) result_d = dz_q ? 32'hFFFF_FFFF : rq_d[31:0];
            else                     result_d = dz_q ? a_q : rq_d[63:32];
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      op_q     <= 2'b00;
      dz_q     <= 1'b0;
      rq_q     <= 64'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      dz_q     <= dz_d;
      rq_q     <= rq_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit: forwarding mux, MUL/DIV/REM
// results and latency, divide by zero, flush and asynchronous reset.
module tb_ex_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [1:0]  op_i;
  logic        flush_i;
  logic [31:0] Rs_data_i, Rt_data_i, EX_MEM_data_i, MEM_WB_data_i;
  logic [1:0]  Rs_fwd_i, Rt_fwd_i;
  logic [31:0] rs_op_o, rt_op_o, result_o;
  logic        done_o, stall_o;

  int n_checks = 0;
  int n_errors = 0;

  ex_muldiv_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .op_i(op_i), .flush_i(flush_i),
    .Rs_data_i(Rs_data_i), .Rt_data_i(Rt_data_i),
    .EX_MEM_data_i(EX_MEM_data_i), .MEM_WB_data_i(MEM_WB_data_i),
    .Rs_fwd_i(Rs_fwd_i), .Rt_fwd_i(Rt_fwd_i),
    .rs_op_o(rs_op_o), .rt_op_o(rt_op_o), .result_o(result_o),
    .done_o(done_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic scramble();
    Rs_data_i = 32'hDEAD_BEEF; Rt_data_i = 32'h0BAD_F00D;
    EX_MEM_data_i = 32'h5555_AAAA; MEM_WB_data_i = 32'h1357_9BDF;
  endtask

  // Issues one op from IDLE, checks the 33-cycle stall window, the done pulse and the result.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [1:0] rsf, input logic [31:0] exm,
                        input logic [31:0] exp);
    int bad;
    Rs_data_i = rs; Rt_data_i = rt; EX_MEM_data_i = exm; MEM_WB_data_i = 32'h0;
    Rs_fwd_i = rsf; Rt_fwd_i = 2'b00; valid_i = 1'b1; op_i = op;
    #1;
    check({tag, " start stall"}, {31'd0, stall_o}, 32'd1);
    step();
    valid_i = 1'b0; op_i = 2'b00;
    scramble();
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      if (stall_o !== 1'b1 || done_o !== 1'b0) bad++;
      step();
    end
    check({tag, " busy window"}, bad, 32'd0);
    check({tag, " done"}, {31'd0, done_o}, 32'd1);
    check({tag, " stall in done"}, {31'd0, stall_o}, 32'd0);
    check({tag, " result"}, result_o, exp);
    step();
    check({tag, " done pulse"}, {31'd0, done_o}, 32'd0);
    check({tag, " result hold"}, result_o, exp);
  endtask

  initial begin
    rst_i = 1'b0; valid_i = 1'b0; op_i = 2'b00; flush_i = 1'b0;
    Rs_data_i = 32'd1; Rt_data_i = 32'd1; EX_MEM_data_i = 32'd2; MEM_WB_data_i = 32'd3;
    Rs_fwd_i = 2'b00; Rt_fwd_i = 2'b00;
    #23;
    check("reset result", result_o, 32'd0);
    check("reset done", {31'd0, done_o}, 32'd0);
    check("reset stall", {31'd0, stall_o}, 32'd0);
    rst_i = 1'b1;
    step();

    begin
      logic [1:0]  sel [4];
      logic [31:0] expv [4];
      sel = '{2'b00, 2'b10, 2'b01, 2'b11};
      expv = '{32'd1, 32'd2, 32'd3, 32'd1};
      for (int i = 0; i < 4; i++) begin
        Rs_fwd_i = sel[i]; Rt_fwd_i = 2'b00; #1;
        check($sformatf("rs mux %0d", i), rs_op_o, expv[i]);
        Rt_fwd_i = sel[i]; Rs_fwd_i = 2'b00; #1;
        check($sformatf("rt mux %0d", i), rt_op_o, expv[i]);
      end
    end

    valid_i = 1'b1; op_i = 2'b00; #1;
    check("alu no stall", {31'd0, stall_o}, 32'd0);
    step();
    check("alu no done", {31'd0, done_o}, 32'd0);
    valid_i = 1'b0;

    run_op("mul", 2'b01, 32'd12345, 32'd6789, 2'b00, 32'd0, 32'h04FE_D79D);
    run_op("mul wrap", 2'b01, 32'h0001_0000, 32'h0001_0000, 2'b00, 32'd0, 32'h0000_0000);
    run_op("div fwd", 2'b10, 32'd0, 32'd7, 2'b10, 32'd100, 32'd14);
    run_op("rem fwd", 2'b11, 32'd0, 32'd7, 2'b10, 32'd100, 32'd2);
    run_op("div0", 2'b10, 32'h1234, 32'd0, 2'b00, 32'd0, 32'hFFFF_FFFF);
    run_op("rem0", 2'b11, 32'h1234, 32'd0, 2'b00, 32'd0, 32'h0000_1234);

    // flush at T+10, then a fresh MUL at T+12
    Rs_data_i = 32'd7; Rt_data_i = 32'd9; Rs_fwd_i = 2'b00; Rt_fwd_i = 2'b00;
    valid_i = 1'b1; op_i = 2'b01;
    step();
    valid_i = 1'b0; op_i = 2'b00;
    for (int i = 0; i < 9; i++) step();
    flush_i = 1'b1; #1;
    check("flush stall", {31'd0, stall_o}, 32'd0);
    check("flush done", {31'd0, done_o}, 32'd0);
    step();
    flush_i = 1'b0; #1;
    check("post flush stall", {31'd0, stall_o}, 32'd0);
    check("post flush done", {31'd0, done_o}, 32'd0);
    check("post flush result", result_o, 32'h0000_1234);
    step();
    run_op("mul after flush", 2'b01, 32'd3, 32'd5, 2'b00, 32'd0, 32'd15);

    // asynchronous reset at T+5
    Rs_data_i = 32'd50; Rt_data_i = 32'd5; valid_i = 1'b1; op_i = 2'b10;
    step();
    valid_i = 1'b0; op_i = 2'b00;
    for (int i = 0; i < 4; i++) step();
    #2;
    rst_i = 1'b0; #1;
    check("rst result", result_o, 32'd0);
    check("rst done", {31'd0, done_o}, 32'd0);
    check("rst stall", {31'd0, stall_o}, 32'd0);
    step();
    rst_i = 1'b1;
    step();
    check("rst idle", {31'd0, stall_o}, 32'd0);
    run_op("div after rst", 2'b10, 32'hFFFF_FFFF, 32'h10, 2'b00, 32'd0, 32'h0FFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
